// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard line receiver and scan-code to key-event decoder
//
// Ports:
//   I_CLK_24576M  system clock
//   I_RESETn      asynchronous active-low reset
//   I_PS2_CLK     raw PS/2 clock (asynchronous, idle high)
//   I_PS2_DAT     raw PS/2 data  (asynchronous, idle high)
//   O_PS2_KEY     {toggle, pressed, extended, code[7:0]}
//   O_KEY_STB     one-cycle pulse in the cycle O_PS2_KEY changes
//   O_FRAME_ERR   one-cycle pulse on parity, stop or timeout error
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 49152
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESETn,
  input  logic        I_PS2_CLK,
  input  logic        I_PS2_DAT,
  output logic [10:0] O_PS2_KEY,
  output logic        O_KEY_STB,
  output logic        O_FRAME_ERR
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fe;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          timeout, err_n, byte_vld_n;

  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          ext, brk;
  logic [2:0]    skip;
  logic          ignorable;

  // Synchronisers and glitch filter; all preset to the idle-high line level.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= I_PS2_CLK;
      clk_s2     <= clk_s1;
      dat_s1     <= I_PS2_DAT;
      dat_s2     <= dat_s1;
      clk_filt_d <= clk_filt;
      // Any sample matching the filtered level restarts the run count,
      // so only FILTER_LEN consecutive differing samples flip the output.
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fe      = clk_filt_d & ~clk_filt;
  assign timeout = (state != S_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      byte_vld <= 1'b0;
      byte_q   <= '0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      to_cnt   <= to_cnt_n;
      byte_vld <= byte_vld_n;
      if (byte_vld_n) byte_q <= shift;
    end
  end

  // Frame FSM; a timeout takes priority over a coincident falling edge.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    par_bit_n  = par_bit;
    to_cnt_n   = '0;
    err_n      = 1'b0;
    byte_vld_n = 1'b0;
    if (state != S_IDLE && !fe) to_cnt_n = to_cnt + TW'(1);
    if (timeout) begin
      state_n  = S_IDLE;
      to_cnt_n = '0;
      err_n    = 1'b1;
    end else if (fe) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
            shift_n   = '0;
          end
        end
        S_DATA: begin
          shift_n   = {dat_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          par_bit_n = dat_s2;
          state_n   = S_STOP;
        end
        default: begin
          state_n = S_IDLE;
          if (dat_s2 && (^shift ^ par_bit)) byte_vld_n = 1'b1;
          else                              err_n      = 1'b1;
        end
      endcase
    end
  end

  // Keyboard status replies and overrun codes carry no key information.
  always_comb begin
    case (byte_q)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ignorable = 1'b1;
      default:                                  ignorable = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      O_PS2_KEY   <= '0;
      O_KEY_STB   <= 1'b0;
      O_FRAME_ERR <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      skip        <= '0;
    end else begin
      O_KEY_STB   <= 1'b0;
      O_FRAME_ERR <= err_n;
      if (byte_vld) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (byte_q == 8'hE1) begin
          skip <= 3'd7;  // rest of the 8-byte Pause sequence
        end else if (byte_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk <= 1'b1;
        end else if (!(ignorable && !ext && !brk)) begin
          O_PS2_KEY <= {~O_PS2_KEY[10], ~brk, ext, byte_q};
          O_KEY_STB <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
      if (err_n) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] key;
  logic        stb, ferr;

  int checks = 0;
  int errors = 0;

  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  int          rd = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  int          spurious = 0;
  logic [10:0] prev_key = '0;

  logic        m_tog = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
  int          m_skip = 0;

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .I_CLK_24576M(clk),
    .I_RESETn    (rst_n),
    .I_PS2_CLK   (ps2_clk),
    .I_PS2_DAT   (ps2_dat),
    .O_PS2_KEY   (key),
    .O_KEY_STB   (stb),
    .O_FRAME_ERR (ferr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stb) obs_q.push_back(key);
      else if (key !== prev_key) spurious++;
      if (ferr) err_seen++;
    end
    prev_key = key;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour of the byte stream, one received frame at a time.
  task automatic model_frame(input logic [7:0] b, input bit bad);
    bit ign;
    ign = (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'h00 || b == 8'hFF);
    if (bad) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (ign && !m_ext && !m_brk) begin end
    else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_brk, m_ext, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk) ps2_dat = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    @(negedge clk) ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    model_frame(b, bad_par || bad_stop);
  endtask

  task automatic sync_check(input string tag);
    repeat (60) @(negedge clk);
    chk({tag, "_events"}, obs_q.size(), exp_q.size());
    chk({tag, "_errs"}, err_seen, exp_err);
    while (rd < obs_q.size() && rd < exp_q.size()) begin
      chk({tag, "_key"}, obs_q[rd], exp_q[rd]);
      rd++;
    end
  endtask

  task automatic chk_last_low(input string tag, input logic [9:0] expv);
    logic [10:0] last;
    last = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 'x;
    chk(tag, last[9:0], expv);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    logic [7:0] ign_set [6];
    ign_set = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    repeat (4) @(negedge clk);
    chk("reset_key", key, 0);
    chk("reset_stb", stb, 0);
    chk("reset_err", ferr, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 0, 0);
    sync_check("make_1c");
    chk_last_low("make_1c_val", 10'h21C);
    chk("make_1c_full", obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 'x, 11'h61C);

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    sync_check("ext_seq");
    chk("ext_make", obs_q.size() >= 3 ? obs_q[1] : 'x, 11'h375);
    chk("ext_break", obs_q.size() >= 3 ? obs_q[2] : 'x, 11'h575);

    send_frame(8'h29, 1, 0);
    sync_check("bad_par");
    send_frame(8'h29, 0, 0);
    sync_check("good_29");
    chk_last_low("good_29_val", 10'h229);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (TIMEOUT + 100) @(negedge clk);
    exp_err++; m_ext = 1'b0; m_brk = 1'b0;
    sync_check("timeout");
    send_frame(8'h16, 0, 0);
    sync_check("after_to");
    chk_last_low("after_to_val", 10'h216);

    send_frame(8'hE1, 0, 0); send_frame(8'h14, 0, 0); send_frame(8'h77, 0, 0);
    send_frame(8'hE1, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h14, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h77, 0, 0);
    sync_check("pause");
    send_frame(8'h05, 0, 0);
    sync_check("after_pause");
    chk_last_low("after_pause_val", 10'h205);

    send_frame(8'hAA, 0, 0); send_frame(8'h12, 0, 1);
    sync_check("ign_stop");

    for (int g = 0; g < 5; g++) begin
      @(negedge clk) ps2_clk = 1'b0;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
    end
    send_bit(1'b1);
    sync_check("glitch");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_key", key, 0);
    chk("midrst_stb", stb, 0);
    chk("midrst_err", ferr, 0);
    m_tog = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 0, 0);
    sync_check("post_rst");
    chk("post_rst_val", obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 'x, 11'h61C);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h5A;
        5:       b = ign_set[$urandom_range(0, 5)];
        default: b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end
    sync_check("random");

    chk("no_spurious_key_change", spurious, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
